cmd_frame_rcv: RTL

CMD_FRAME_RCV -- requirements
Module: cmd_frame_rcv

---
 rtl/cmd_frame_rcv.sv | 127 ++++++++++++
 1 files changed

// File: rtl/cmd_frame_rcv.sv
// Command frame receiver: SOF, cmd, data hi, data lo, checksum.
// Bytes come from a UART receiver with a rdy/clr_rdy handshake; a frame
// is valid when cmd+hi+lo+chk wraps to 8'hFF. A stalled frame is
// abandoned after TIMEOUT_CLKS cycles without a new byte.
module cmd_frame_rcv #(
   parameter int         TIMEOUT_CLKS = 1000000,
   parameter logic [7:0] SOF_BYTE     = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rdy,
   output logic        clr_rdy,
   output logic [7:0]  cmd,
   output logic [15:0] data,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   output logic        frm_err
);

   localparam int CW = $clog2(TIMEOUT_CLKS) + 1;

   typedef enum logic [2:0] {IDLE, CMD, DHI, DLO, CHK} state_t;

   state_t          state, state_nxt;
   logic            accept;
   logic            to_hit;
   logic            load;
   logic            err_nxt;
   logic [CW-1:0]   to_cnt;
   logic [7:0]      sh_cmd, sh_hi, sh_lo;
   logic [7:0]      sum;

   // clr_rdy is high the cycle after an acceptance, so the same rdy
   // level is never taken twice.
   assign accept = rdy & ~clr_rdy;
   assign sum    = sh_cmd + sh_hi + sh_lo + rx_data;
   // A byte arriving on the terminal count wins over the timeout.
   assign to_hit = (state != IDLE) && (to_cnt == CW'(TIMEOUT_CLKS - 1)) && !accept;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state, frame load strobe and abort strobe
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      err_nxt   = 1'b0;
      case (state)
         IDLE: if (accept && rx_data == SOF_BYTE) state_nxt = CMD;
         CMD: begin
            if (accept)      state_nxt = DHI;
            else if (to_hit) begin state_nxt = IDLE; err_nxt = 1'b1; end
         end
         DHI: begin
            if (accept)      state_nxt = DLO;
            else if (to_hit) begin state_nxt = IDLE; err_nxt = 1'b1; end
         end
         DLO: begin
            if (accept)      state_nxt = CHK;
            else if (to_hit) begin state_nxt = IDLE; err_nxt = 1'b1; end
         end
         CHK: begin
            if (accept) begin
               state_nxt = IDLE;
               if (sum == 8'hFF) load    = 1'b1;
               else              err_nxt = 1'b1;
            end else if (to_hit) begin
               state_nxt = IDLE;
               err_nxt   = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Byte acknowledge back to the UART receiver
   always_ff @(posedge clk) begin
      if (rst) clr_rdy <= 1'b0;
      else     clr_rdy <= accept;
   end

   // Inter-byte timeout counter; cleared on every byte and while idle,
   // and on the timeout itself so it can never wrap.
   always_ff @(posedge clk) begin
      if (rst || state == IDLE || accept || to_hit) to_cnt <= '0;
      else                                         to_cnt <= to_cnt + CW'(1);
   end

   // Shadow registers keep the outputs stable while a frame arrives
   always_ff @(posedge clk) begin
      if (rst) begin
         sh_cmd <= 8'h00;
         sh_hi  <= 8'h00;
         sh_lo  <= 8'h00;
      end else if (accept) begin
         if (state == CMD) sh_cmd <= rx_data;
         if (state == DHI) sh_hi  <= rx_data;
         if (state == DLO) sh_lo  <= rx_data;
      end
   end

   // Published command; a load in the same cycle as the ack keeps cmd_rdy set
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd     <= 8'h00;
         data    <= 16'h0000;
         cmd_rdy <= 1'b0;
      end else if (load) begin
         cmd     <= sh_cmd;
         data    <= {sh_hi, sh_lo};
         cmd_rdy <= 1'b1;
      end else if (clr_cmd_rdy) begin
         cmd_rdy <= 1'b0;
      end
   end

   // One-cycle abort pulse (bad checksum or timeout)
   always_ff @(posedge clk) begin
      if (rst) frm_err <= 1'b0;
      else     frm_err <= err_nxt;
   end

endmodule
